misr_sig_checker: RTL and testbench

// - Parametrised multiple-input signature register (MISR) with a built-in test-session controller.
// - Compresses N_IN parallel response bits per valid cycle into a WIDTH-bit signature.
// - Counts N_PAT valid samples, then compares the signature against a golden value and flags pass/fail.
// - Sits at the output of the circuit under test in the BIST path. Successor to the fixed 12-bit, 3-input MISR.

---
 rtl/misr_sig_checker.sv | 119 +++++++++++
 tb/tb_misr_sig_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/misr_sig_checker.sv
// Multiple-input signature register with a session controller: compresses N_IN
// response bits per valid cycle and flags pass/fail against a golden signature.
module misr_sig_checker #(
    parameter int unsigned           WIDTH = 12,
    parameter int unsigned           N_IN  = 3,
    parameter logic [WIDTH-1:0]      POLY  = WIDTH'(12'h829),
    parameter logic [WIDTH-1:0]      SEED  = '0,
    parameter int unsigned           N_PAT = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             din_valid,
    input  logic [N_IN-1:0]  din,
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] sig
);

    localparam int unsigned CW = $clog2(N_PAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sig;
    logic [WIDTH-1:0] w_sig_nxt;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_pass;
    logic             w_pass_nxt;

    logic             w_fb;
    logic [WIDTH-1:0] w_din_ext;
    logic [WIDTH-1:0] w_step;
    logic             w_last;

    // One compression step of the current signature with the incoming sample
    assign w_fb      = ^(r_sig & POLY);
    assign w_din_ext = WIDTH'(din);
    assign w_step    = {r_sig[WIDTH-2:0], w_fb} ^ w_din_ext;
    assign w_last    = (r_count == CW'(N_PAT - 1));

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_sig_nxt   = r_sig;
        w_count_nxt = r_count;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_sig_nxt   = SEED;
                    w_count_nxt = '0;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                end
            end
            S_RUN: begin
                if (start) begin
                    // Abort: the sample presented alongside start is dropped
                    w_sig_nxt   = SEED;
                    w_count_nxt = '0;
                end else if (din_valid) begin
                    w_sig_nxt   = w_step;
                    w_count_nxt = r_count + CW'(1);
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_step == golden);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_RUN);
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_sig   <= SEED;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sig   <= w_sig_nxt;
            r_count <= w_count_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign pass = r_pass;
    assign sig  = r_sig;

endmodule

// File: tb/tb_misr_sig_checker.sv
// Bench for misr_sig_checker: a small 4-bit instance for directed scenarios and a
// default-parameter instance checked against a bit-serial reference model.
module tb_misr_sig_checker;

    localparam logic [3:0]  P4    = 4'b1001;
    localparam logic [3:0]  SEED4 = 4'b0001;
    localparam logic [11:0] P12   = 12'h829;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0, din_valid = 1'b0;
    logic [0:0]  din = '0;
    logic [3:0]  golden = '0;
    logic        busy, done, pass;
    logic [3:0]  sig;

    logic        start2 = 1'b0, din_valid2 = 1'b0;
    logic [2:0]  din2 = '0;
    logic [11:0] golden2 = '0;
    logic        busy2, done2, pass2;
    logic [11:0] sig2;

    int total = 0;
    int bad   = 0;
    logic [4:0]  q4[$];
    logic [12:0] q12[$];
    logic [3:0]  m4;
    logic [11:0] m12;

    always #5 CLK = ~CLK;

    misr_sig_checker #(.WIDTH(4), .N_IN(1), .POLY(P4), .SEED(SEED4), .N_PAT(4)) dut (
        .CLK(CLK), .RST(RST), .start(start), .din_valid(din_valid), .din(din),
        .golden(golden), .busy(busy), .done(done), .pass(pass), .sig(sig)
    );

    misr_sig_checker dut2 (
        .CLK(CLK), .RST(RST), .start(start2), .din_valid(din_valid2), .din(din2),
        .golden(golden2), .busy(busy2), .done(done2), .pass(pass2), .sig(sig2)
    );

    function automatic logic [3:0] step4(input logic [3:0] s, input logic d);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < 4; i++) if (P4[i]) fb = fb ^ s[i];
        return {s[2:0], fb} ^ {3'b000, d};
    endfunction

    function automatic logic [11:0] step12(input logic [11:0] s, input logic [2:0] d);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < 12; i++) if (P12[i]) fb = fb ^ s[i];
        return {s[10:0], fb} ^ {9'b0, d};
    endfunction

    // One clock of stimulus on the small instance; outputs are stable on return
    task automatic cyc4(input logic st, input logic v, input logic d);
        @(negedge CLK);
        start = st; din_valid = v; din = d;
        @(posedge CLK);
        #1;
        start = 1'b0; din_valid = 1'b0;
    endtask

    task automatic cyc12(input logic st, input logic v, input logic [2:0] d);
        @(negedge CLK);
        start2 = st; din_valid2 = v; din2 = d;
        @(posedge CLK);
        #1;
        start2 = 1'b0; din_valid2 = 1'b0;
    endtask

    // Start plus four samples with optional invalid gaps; expected result queued
    task automatic drive_session4(input logic [3:0] bits, input int gap, input logic [3:0] gold);
        golden = gold;
        cyc4(1'b1, 1'b0, 1'b0);
        m4 = SEED4;
        for (int i = 0; i < 4; i++) begin
            repeat (gap) cyc4(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            m4 = step4(m4, bits[i]);
            if (i == 3) q4.push_back({(m4 == gold), m4});
            cyc4(1'b0, 1'b1, bits[i]);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (2) begin
            golden = 4'($urandom);
            cyc4(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        total++; if (sig !== 4'b0001) begin bad++; $display("FAIL reset_sig got=%b want=0001", sig); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", pass); end
        total++; if (sig2 !== 12'h000) begin bad++; $display("FAIL reset_sig2 got=%h want=000", sig2); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_zero_data;
        logic [3:0] exp_steps [4];
        exp_steps = '{4'b0011, 4'b0111, 4'b1111, 4'b1110};
        golden = 4'b1110;
        cyc4(1'b1, 1'b1, 1'b1);
        total++; if (busy !== 1'b1 || sig !== 4'b0001) begin bad++;
            $display("FAIL zero_start got busy=%b sig=%b want busy=1 sig=0001", busy, sig); end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q4.push_back({1'b1, exp_steps[i]});
            cyc4(1'b0, 1'b1, 1'b0);
            total++; if (sig !== exp_steps[i]) begin bad++;
                $display("FAIL zero_step%0d got=%b want=%b", i, sig, exp_steps[i]); end
            if (i == 2) begin
                total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++;
                    $display("FAIL zero_early got done=%b busy=%b want done=0 busy=1", done, busy); end
            end
        end
        begin
            logic [4:0] e;
            e = q4.pop_front();
            total++; if (done !== 1'b1 || pass !== e[4] || busy !== 1'b0) begin bad++;
                $display("FAIL zero_final got done=%b pass=%b busy=%b want 1 %b 0", done, pass, busy, e[4]); end
        end
    endtask

    task automatic test_inject_fail;
        logic [4:0] e;
        golden = 4'b1110;
        cyc4(1'b1, 1'b0, 1'b0);
        cyc4(1'b0, 1'b1, 1'b1);
        total++; if (sig !== 4'b0010) begin bad++; $display("FAIL inject_first got=%b want=0010", sig); end
        m4 = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            m4 = step4(m4, 1'b0);
            if (i == 2) q4.push_back({(m4 == golden), m4});
            cyc4(1'b0, 1'b1, 1'b0);
        end
        e = q4.pop_front();
        total++; if (sig !== e[3:0]) begin bad++; $display("FAIL inject_sig got=%b want=%b", sig, e[3:0]); end
        total++; if (done !== 1'b1 || pass !== 1'b0) begin bad++;
            $display("FAIL inject_result got done=%b pass=%b want done=1 pass=0", done, pass); end
    endtask

    task automatic test_gaps_restart;
        logic [4:0] e;
        drive_session4(4'b0000, 3, 4'b1110);
        e = q4.pop_front();
        total++; if (done !== 1'b1 || sig !== e[3:0] || pass !== e[4]) begin bad++;
            $display("FAIL gaps_final got done=%b sig=%b pass=%b want 1 %b %b", done, sig, pass, e[3:0], e[4]); end
        cyc4(1'b0, 1'b1, 1'b1);
        total++; if (done !== 1'b1 || sig !== 4'b1110 || pass !== 1'b1) begin bad++;
            $display("FAIL done_frozen got done=%b sig=%b pass=%b want 1 1110 1", done, sig, pass); end
        golden = 4'b0000;
        cyc4(1'b1, 1'b0, 1'b0);
        total++; if (done !== 1'b0 || busy !== 1'b1 || sig !== 4'b0001) begin bad++;
            $display("FAIL restart got done=%b busy=%b sig=%b want 0 1 0001", done, busy, sig); end
    endtask

    task automatic test_abort;
        logic [4:0] e;
        golden = 4'b1110;
        cyc4(1'b1, 1'b0, 1'b0);
        cyc4(1'b0, 1'b1, 1'b1);
        cyc4(1'b0, 1'b1, 1'b1);
        cyc4(1'b1, 1'b1, 1'b1);
        total++; if (sig !== 4'b0001 || busy !== 1'b1 || done !== 1'b0) begin bad++;
            $display("FAIL abort_restart got sig=%b busy=%b done=%b want 0001 1 0", sig, busy, done); end
        m4 = SEED4;
        for (int i = 0; i < 4; i++) begin
            m4 = step4(m4, 1'b0);
            if (i == 3) q4.push_back({(m4 == golden), m4});
            cyc4(1'b0, 1'b1, 1'b0);
        end
        e = q4.pop_front();
        total++; if (done !== 1'b1 || sig !== e[3:0] || pass !== e[4]) begin bad++;
            $display("FAIL abort_final got done=%b sig=%b pass=%b want 1 %b %b", done, sig, pass, e[3:0], e[4]); end
    endtask

    task automatic test_reset_mid_run;
        golden = 4'b0011;
        cyc4(1'b1, 1'b0, 1'b0);
        cyc4(1'b0, 1'b1, 1'b0);
        cyc4(1'b0, 1'b1, 1'b0);
        RST = 1'b1;
        cyc4(1'b0, 1'b1, 1'b1);
        RST = 1'b0;
        total++; if (busy !== 1'b0 || sig !== SEED4 || done !== 1'b0) begin bad++;
            $display("FAIL midrst got busy=%b sig=%b done=%b want 0 0001 0", busy, sig, done); end
        repeat (5) cyc4(1'b0, 1'b1, 1'b0);
        total++; if (done !== 1'b0 || sig !== SEED4) begin bad++;
            $display("FAIL midrst_idle got done=%b sig=%b want done=0 sig=0001", done, sig); end
    endtask

    task automatic test_default_smoke(input logic want_pass);
        logic [2:0]  samples [16];
        logic [12:0] e;
        int          n;
        m12 = 12'h000;
        for (int i = 0; i < 16; i++) begin
            samples[i] = 3'($urandom);
            m12 = step12(m12, samples[i]);
        end
        golden2 = want_pass ? m12 : (m12 ^ 12'h001);
        q12.push_back({want_pass, m12});
        cyc12(1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 2)) cyc12(1'b0, 1'b0, 3'($urandom));
            cyc12(1'b0, 1'b1, samples[i]);
            if (i < 15 && done2 !== 1'b0) begin
                total++; bad++; $display("FAIL smoke_early got done2=1 at sample %0d want 0", i);
            end
        end
        n = 0;
        while (done2 !== 1'b1 && n < 4) begin
            cyc12(1'b0, 1'b0, 3'b000);
            n++;
        end
        e = q12.pop_front();
        total++; if (done2 !== 1'b1 || n != 0) begin bad++;
            $display("FAIL smoke_latency got done2=%b extra_cycles=%0d want done2=1 extra=0", done2, n); end
        total++; if (sig2 !== e[11:0] || pass2 !== e[12] || busy2 !== 1'b0) begin bad++;
            $display("FAIL smoke_result got sig=%h pass=%b busy=%b want %h %b 0", sig2, pass2, busy2, e[11:0], e[12]); end
    endtask

    initial begin
        test_reset();
        test_zero_data();
        test_inject_fail();
        test_gaps_restart();
        test_abort();
        test_reset_mid_run();
        test_default_smoke(1'b1);
        test_default_smoke(1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
